eh2_dccm_req_seq: RTL and testbench
===================================

# eh2_dccm_req_seq

Initiator-side sequencer that drives the DCCM array port (write enable, read enable, addresses, 39-bit ECC-protected data) on behalf of one load/store client. Accepts word reads, full-word writes and sub-word (byte-enable) writes, performs read-modify-write for partial stores, and generates and checks 32-bit SECDED ECC. It returns corrected read data with error flags. Sits between the LSU request path and the DCCM memory wrapper, which has a fixed 1-cycle read latency.

## Interface
Parameters:
- DCCM_BITS, 16, byte-address width into DCCM.
- DCCM_FDATA_WIDTH, 39, stored word width: 32 data bits plus 7 ECC bits in [38:32].

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  client request valid.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  DCCM_BITS  byte address; bits [1:0] are ignored (word-aligned).
- req_wdata  in  32  store data.
- req_be  in  4  store byte enables; 4'hF = full word; ignored for loads.
- ecc_disable  in  1  bypasses ECC checking and correction.
- rsp_valid  out  1  one-cycle pulse: load data valid. There is no backpressure.
- rsp_rdata  out  32  corrected load data.
- rsp_sb_err  out  1  single-bit error detected and corrected; qualified by rsp_valid.
- rsp_db_err  out  1  uncorrectable error; qualified by rsp_valid.
- rmw_err  out  1  one-cycle pulse: partial store aborted on a double-bit error.
- dccm_wren  out  1  array write enable.
- dccm_rden  out  1  array read enable.
- dccm_wr_addr  out  DCCM_BITS  write address.
- dccm_rd_addr  out  DCCM_BITS  read address.
- dccm_wr_data  out  DCCM_FDATA_WIDTH  write data with ECC.
- dccm_rd_data  in  DCCM_FDATA_WIDTH  read data; valid the cycle after dccm_rden.

## Operation
- States: IDLE, WR, RD, CHK, MERGE, CORR (CORR exists only with the macro enabled).
- IDLE:
  - Accept a store with be=F, going to WR.
  - Accept a store with be≠F, going to RD (RMW flag set).
  - Accept a load, going to RD.
- WR: dccm_wren=1 with the registered address and {ecc(data), data}; then go to IDLE.
- RD: dccm_rden=1 with the registered address; then go to CHK.
- CHK: decode dccm_rd_data using the team's SECDED decode.
  - Load: register rsp_* and go to CORR if a single-bit error occurred and the macro is enabled, else go to IDLE.
  - RMW with a double-bit error: pulse rmw_err, perform no write, go to IDLE.
  - RMW otherwise: go to MERGE.
- MERGE: for each byte i, the new byte is req_wdata if be[i], else the corrected old byte. Re-encode the word and go to WR.
- CORR: dccm_wren=1 with the corrected word re-encoded at the same address; then go to IDLE.
- ecc_disable=1: raw bits [31:0] are returned and both error flags are 0. There is no correction writeback, and RMW never aborts.
- ECC: 6 Hamming bits plus 1 overall parity bit, using the existing encode/decode functions.
- Address passes through unchanged, with bits [1:0] forced to 0.

## Timing
- Full store accepted in cycle N: dccm_wren in N+1, req_ready in N+2.
- Load accepted in N:
  - dccm_rden in N+1, data sampled in N+2.
  - rsp_valid in N+3.
  - With CORR: writeback dccm_wren in N+3, req_ready in N+4.
  - Without CORR: req_ready in N+3.
- Partial store accepted in N: rden N+1, check N+2, merge N+3, wren N+4, req_ready N+5.
- At most one request is in flight; there is no pipelining. req_ready is combinational from state == IDLE.
- dccm_wren and dccm_rden are never high in the same cycle.
- Reset values:
  - All outputs 0, state IDLE, internal registers cleared.
  - req_ready is 0 while rst=1 and 1 in the first cycle after reset.
- Reset mid-operation aborts the operation. No dccm_wren or rsp_valid may occur in the cycle after rst deasserts.

## Configuration
- EH2_DCCM_CORR_WB_EN:
  - Defined: a load that hits a correctable error triggers the CORR writeback state.
  - Undefined: the CORR state is absent and the array is never scrubbed. Loads still return corrected data with rsp_sb_err=1.

## Test plan
- Full store: addr 0x0040, data 0xDEADBEEF, be F. Required: one dccm_wren at 0x0040, dccm_wr_data[31:0]=0xDEADBEEF with correct ECC, no dccm_rden.
- Load of a clean word 0x12345678 from 0x0040. Required: rsp_valid in N+3, rdata 0x12345678, both error flags 0.
- Partial store with be=4'b0010, data 0x0000AB00, over stored 0x12345678. Required: a read followed by a write of 0x1234AB78 with fresh ECC.
- Stored data bit 5 flipped on a load (macro defined). Required: rdata corrected, rsp_sb_err=1, writeback in N+3 of the clean encoded word. Macro undefined: same response, no write.
- Two bits flipped:
  - Load: rsp_db_err=1.
  - Partial store: rmw_err pulse and no dccm_wren.
  - ecc_disable=1: raw data, flags 0.
- rst asserted during the RD state of a partial store. Required: no write afterwards, req_ready=1 one cycle after rst falls.

Source files
------------

// File: rtl/eh2_dccm_req_seq.sv
// ---------------------------------------------------------------------------
// eh2_dccm_req_seq
//
// Sequences one load/store client onto the DCCM array port. Full-word stores
// are written directly. Partial stores do a read-modify-write. Loads return
// SECDED-corrected data with error flags. The array has a fixed 1-cycle read
// latency.
//
// Optional feature macro: EH2_DCCM_CORR_WB_EN. When it is defined, a load that
// hits a correctable error writes the corrected word back (CORR state).
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid/o_req_ready request handshake (ready only in IDLE)
//   i_req_write             1 = store, 0 = load
//   i_req_addr              byte address, bits [1:0] ignored
//   i_req_wdata, i_req_be   store data and byte enables
//   i_ecc_disable           bypass ECC check/correction
//   o_rsp_valid             load response pulse
//   o_rsp_rdata             load data (corrected)
//   o_rsp_sb_err            single-bit error corrected
//   o_rsp_db_err            uncorrectable error
//   o_rmw_err               partial store aborted on an uncorrectable error
//   o_dccm_wren/o_dccm_rden array write/read enables
//   o_dccm_wr_addr/rd_addr  array addresses
//   o_dccm_wr_data          array write data {ecc[6:0], data[31:0]}
//   i_dccm_rd_data          array read data, valid the cycle after rden
// ---------------------------------------------------------------------------
module eh2_dccm_req_seq #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic                        i_req_write,
    input  logic [DCCM_BITS-1:0]        i_req_addr,
    input  logic [31:0]                 i_req_wdata,
    input  logic [3:0]                  i_req_be,
    input  logic                        i_ecc_disable,
    output logic                        o_rsp_valid,
    output logic [31:0]                 o_rsp_rdata,
    output logic                        o_rsp_sb_err,
    output logic                        o_rsp_db_err,
    output logic                        o_rmw_err,
    output logic                        o_dccm_wren,
    output logic                        o_dccm_rden,
    output logic [DCCM_BITS-1:0]        o_dccm_wr_addr,
    output logic [DCCM_BITS-1:0]        o_dccm_rd_addr,
    output logic [DCCM_FDATA_WIDTH-1:0] o_dccm_wr_data,
    input  logic [DCCM_FDATA_WIDTH-1:0] i_dccm_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CHK,
        S_MERGE
`ifdef EH2_DCCM_CORR_WB_EN
        , S_CORR
`endif
    } t_state;

    // Hamming check bits: data bits occupy codeword positions 3..38 that are
    // not powers of two; the check value is the XOR of the positions of all
    // set data bits.
    function automatic logic [5:0] f_hamming(input logic [31:0] d);
        logic [31:0] v;
        logic [5:0]  h;
        v = d;
        h = '0;
        for (int p = 3; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (v[0]) h = h ^ p[5:0];
                v = v >> 1;
            end
        end
        return h;
    endfunction

    // Stored word: {overall parity, hamming[5:0], data[31:0]}.
    function automatic logic [DCCM_FDATA_WIDTH-1:0] f_encode(input logic [31:0] d);
        logic [5:0] h;
        h = f_hamming(d);
        return {^{h, d}, h, d};
    endfunction

    t_state                      r_state;
    t_state                      w_state_d;
    logic [DCCM_BITS-1:0]        r_addr;
    logic [31:0]                 r_wdata;
    logic [3:0]                  r_be;
    logic                        r_rmw;
    logic [31:0]                 r_old;
    logic [DCCM_FDATA_WIDTH-1:0] r_wr_word;
    logic                        r_rsp_valid;
    logic [31:0]                 r_rsp_rdata;
    logic                        r_rsp_sb_err;
    logic                        r_rsp_db_err;
    logic                        r_rmw_err;

    logic                        w_wren;
    logic                        w_rden;
    logic [31:0]                 w_raw;
    logic [5:0]                  w_syndrome;
    logic                        w_parity_odd;
    logic [31:0]                 w_flip;
    logic [31:0]                 w_bit;
    logic [31:0]                 w_corr;
    logic                        w_sb;
    logic                        w_db;
    logic [31:0]                 w_be_mask;
    logic [31:0]                 w_merged;

    // SECDED decode of the array read data.
    assign w_raw        = i_dccm_rd_data[31:0];
    assign w_syndrome   = i_dccm_rd_data[37:32] ^ f_hamming(w_raw);
    assign w_parity_odd = ^i_dccm_rd_data;

    // The syndrome names the codeword position in error; map it back to a
    // data bit. Check-bit positions never match, so they leave data intact.
    always_comb begin
        w_flip = '0;
        w_bit  = 32'h1;
        for (int p = 3; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (p[5:0] == w_syndrome) w_flip = w_flip | w_bit;
                w_bit = w_bit << 1;
            end
        end
    end

    assign w_sb   = !i_ecc_disable && w_parity_odd;
    assign w_db   = !i_ecc_disable && !w_parity_odd && (w_syndrome != 6'd0);
    assign w_corr = w_sb ? (w_raw ^ w_flip) : w_raw;

    assign w_be_mask = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
    assign w_merged  = (r_wdata & w_be_mask) | (r_old & ~w_be_mask);

    always_comb begin
        w_state_d = r_state;
        w_wren    = 1'b0;
        w_rden    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_state_d = (i_req_write && (i_req_be == 4'hF)) ? S_WR : S_RD;
                end
            end
            S_WR: begin
                w_wren    = 1'b1;
                w_state_d = S_IDLE;
            end
            S_RD: begin
                w_rden    = 1'b1;
                w_state_d = S_CHK;
            end
            S_CHK: begin
                if (r_rmw) begin
                    w_state_d = w_db ? S_IDLE : S_MERGE;
                end else begin
`ifdef EH2_DCCM_CORR_WB_EN
                    w_state_d = w_sb ? S_CORR : S_IDLE;
`else
                    w_state_d = S_IDLE;
`endif
                end
            end
            S_MERGE: w_state_d = S_WR;
`ifdef EH2_DCCM_CORR_WB_EN
            S_CORR: begin
                w_wren    = 1'b1;
                w_state_d = S_IDLE;
            end
`endif
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_rmw        <= 1'b0;
            r_old        <= '0;
            r_wr_word    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_sb_err <= 1'b0;
            r_rsp_db_err <= 1'b0;
            r_rmw_err    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_rsp_valid <= 1'b0;
            r_rmw_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_addr    <= i_req_addr & ~DCCM_BITS'(3);
                        r_wdata   <= i_req_wdata;
                        r_be      <= i_req_be;
                        r_rmw     <= i_req_write && (i_req_be != 4'hF);
                        r_wr_word <= f_encode(i_req_wdata);
                    end
                end
                S_CHK: begin
                    if (!r_rmw) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_rdata  <= w_corr;
                        r_rsp_sb_err <= w_sb;
                        r_rsp_db_err <= w_db;
`ifdef EH2_DCCM_CORR_WB_EN
                        r_wr_word    <= f_encode(w_corr);
`endif
                    end else if (w_db) begin
                        r_rmw_err <= 1'b1;
                    end else begin
                        r_old <= w_corr;
                    end
                end
                S_MERGE: r_wr_word <= f_encode(w_merged);
                default: ;
            endcase
        end
    end

    // Handshake and array strobes are forced low while reset is asserted.
    assign o_req_ready    = !i_rst && (r_state == S_IDLE);
    assign o_dccm_wren    = !i_rst && w_wren;
    assign o_dccm_rden    = !i_rst && w_rden;
    assign o_dccm_wr_addr = r_addr;
    assign o_dccm_rd_addr = r_addr;
    assign o_dccm_wr_data = r_wr_word;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_rsp_sb_err   = r_rsp_sb_err;
    assign o_rsp_db_err   = r_rsp_db_err;
    assign o_rmw_err      = r_rmw_err;

endmodule

// File: tb/tb_eh2_dccm_req_seq.sv
// ---------------------------------------------------------------------------
// tb_eh2_dccm_req_seq
//
// Self-checking bench for eh2_dccm_req_seq. A behavioural DCCM array with
// 1-cycle read latency and a read-side bit-flip mask sits on the array port.
// Expected data and ECC come from a check-bit-wise SECDED reference encoder
// and a word-level scoreboard. Honours EH2_DCCM_CORR_WB_EN.
// ---------------------------------------------------------------------------
module tb_eh2_dccm_req_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        ecc_disable = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_sb_err;
    logic        rsp_db_err;
    logic        rmw_err;
    logic        dccm_wren;
    logic        dccm_rden;
    logic [15:0] dccm_wr_addr;
    logic [15:0] dccm_rd_addr;
    logic [38:0] dccm_wr_data;
    logic [38:0] dccm_rd_data = '0;

    logic [38:0] mem [0:16383];
    logic [38:0] flip = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Per-transaction observations (cycle 1 = first cycle after acceptance).
    int          t_wr_cyc, t_wr_cnt, t_rd_cyc, t_rd_cnt, t_rsp_cyc, t_rmw_cnt, t_rdy_cyc, t_both;
    logic [15:0] t_wr_addr, t_rd_addr;
    logic [38:0] t_wr_data;
    logic [31:0] t_rsp_data;
    logic        t_rsp_sb, t_rsp_db;

    logic [31:0] smem [0:7];

    eh2_dccm_req_seq #(
        .DCCM_BITS       (16),
        .DCCM_FDATA_WIDTH(39)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_write   (req_write),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .i_req_be      (req_be),
        .i_ecc_disable (ecc_disable),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_sb_err  (rsp_sb_err),
        .o_rsp_db_err  (rsp_db_err),
        .o_rmw_err     (rmw_err),
        .o_dccm_wren   (dccm_wren),
        .o_dccm_rden   (dccm_rden),
        .o_dccm_wr_addr(dccm_wr_addr),
        .o_dccm_rd_addr(dccm_rd_addr),
        .o_dccm_wr_data(dccm_wr_data),
        .i_dccm_rd_data(dccm_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dccm_wren) mem[dccm_wr_addr[15:2]] <= dccm_wr_data;
        if (dccm_rden) dccm_rd_data <= mem[dccm_rd_addr[15:2]] ^ flip;
    end

    // Reference SECDED word: check bit k is the parity of every data bit whose
    // codeword position (non-powers of two, 3..38) has bit k set.
    function automatic logic [38:0] ref_word(input logic [31:0] d);
        logic [6:0]  e;
        logic [31:0] v;
        logic        b;
        e = '0;
        for (int k = 0; k < 6; k++) begin
            v = d;
            b = 1'b0;
            for (int p = 1; p <= 38; p++) begin
                if ((p & (p - 1)) != 0) begin
                    if (((p >> k) & 1) == 1) b = b ^ v[0];
                    v = v >> 1;
                end
            end
            e = e | (7'(b) << k);
        end
        e = e | (7'(^{e[5:0], d}) << 6);
        return {e, d};
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (((be >> i) & 4'h1) == 4'h1) begin
                r = (r & ~(32'hFF << (8 * i))) | (nw & (32'hFF << (8 * i)));
            end
        end
        return r;
    endfunction

    // Issue one request from an idle DUT and record 8 cycles of activity.
    task automatic do_txn(input logic w, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] be);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        t_wr_cyc = -1; t_wr_cnt = 0; t_rd_cyc = -1; t_rd_cnt = 0; t_rsp_cyc = -1;
        t_rmw_cnt = 0; t_rdy_cyc = -1; t_both = 0;
        for (int c = 1; c <= 8; c++) begin
            if (dccm_wren) begin
                if (t_wr_cyc < 0) t_wr_cyc = c;
                t_wr_cnt++;
                t_wr_addr = dccm_wr_addr;
                t_wr_data = dccm_wr_data;
            end
            if (dccm_rden) begin
                if (t_rd_cyc < 0) t_rd_cyc = c;
                t_rd_cnt++;
                t_rd_addr = dccm_rd_addr;
            end
            if (dccm_wren && dccm_rden) t_both++;
            if (rsp_valid && t_rsp_cyc < 0) begin
                t_rsp_cyc  = c;
                t_rsp_data = rsp_rdata;
                t_rsp_sb   = rsp_sb_err;
                t_rsp_db   = rsp_db_err;
            end
            if (rmw_err) t_rmw_cnt++;
            if (req_ready && t_rdy_cyc < 0) t_rdy_cyc = c;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready_in_reset got %b want 0", req_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready_after got %b want 1", req_ready); end
        n_checks++; if ({dccm_wren, dccm_rden, rsp_valid, rmw_err} !== 4'b0) begin n_errors++; $display("FAIL rst_strobes got %b want 0000", {dccm_wren, dccm_rden, rsp_valid, rmw_err}); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_rdata got %h want 0", rsp_rdata); end
        n_checks++; if (dccm_wr_data !== 39'h0) begin n_errors++; $display("FAIL rst_wr_data got %h want 0", dccm_wr_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_store();
        do_txn(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF);
        n_checks++; if (t_wr_cyc !== 1) begin n_errors++; $display("FAIL fs_wr_cyc got %0d want 1", t_wr_cyc); end
        n_checks++; if (t_wr_cnt !== 1) begin n_errors++; $display("FAIL fs_wr_cnt got %0d want 1", t_wr_cnt); end
        n_checks++; if (t_wr_addr !== 16'h0040) begin n_errors++; $display("FAIL fs_wr_addr got %h want 0040", t_wr_addr); end
        n_checks++; if (t_wr_data !== ref_word(32'hDEADBEEF)) begin n_errors++; $display("FAIL fs_wr_data got %h want %h", t_wr_data, ref_word(32'hDEADBEEF)); end
        n_checks++; if (t_rd_cnt !== 0) begin n_errors++; $display("FAIL fs_rd_cnt got %0d want 0", t_rd_cnt); end
        n_checks++; if (t_rdy_cyc !== 2) begin n_errors++; $display("FAIL fs_rdy_cyc got %0d want 2", t_rdy_cyc); end
        // Unaligned top address: low bits dropped.
        do_txn(1'b1, 16'hFFFF, 32'h0BADF00D, 4'hF);
        n_checks++; if (t_wr_addr !== 16'hFFFC) begin n_errors++; $display("FAIL fs_top_addr got %h want fffc", t_wr_addr); end
        do_txn(1'b1, 16'h0040, 32'h12345678, 4'hF);
    endtask

    task automatic test_clean_load();
        do_txn(1'b0, 16'h0042, 32'h0, 4'h0);
        n_checks++; if (t_rd_cyc !== 1) begin n_errors++; $display("FAIL ld_rd_cyc got %0d want 1", t_rd_cyc); end
        n_checks++; if (t_rd_addr !== 16'h0040) begin n_errors++; $display("FAIL ld_rd_addr got %h want 0040", t_rd_addr); end
        n_checks++; if (t_rsp_cyc !== 3) begin n_errors++; $display("FAIL ld_rsp_cyc got %0d want 3", t_rsp_cyc); end
        n_checks++; if (t_rsp_data !== 32'h12345678) begin n_errors++; $display("FAIL ld_rdata got %h want 12345678", t_rsp_data); end
        n_checks++; if ({t_rsp_sb, t_rsp_db} !== 2'b00) begin n_errors++; $display("FAIL ld_flags got %b want 00", {t_rsp_sb, t_rsp_db}); end
        n_checks++; if (t_wr_cnt !== 0) begin n_errors++; $display("FAIL ld_wr_cnt got %0d want 0", t_wr_cnt); end
        n_checks++; if (t_rdy_cyc !== 3) begin n_errors++; $display("FAIL ld_rdy_cyc got %0d want 3", t_rdy_cyc); end
    endtask

    task automatic test_partial_store();
        do_txn(1'b1, 16'h0040, 32'h0000AB00, 4'b0010);
        n_checks++; if (t_rd_cyc !== 1) begin n_errors++; $display("FAIL ps_rd_cyc got %0d want 1", t_rd_cyc); end
        n_checks++; if (t_wr_cyc !== 4) begin n_errors++; $display("FAIL ps_wr_cyc got %0d want 4", t_wr_cyc); end
        n_checks++; if (t_wr_data !== ref_word(32'h1234AB78)) begin n_errors++; $display("FAIL ps_wr_data got %h want %h", t_wr_data, ref_word(32'h1234AB78)); end
        n_checks++; if (t_rdy_cyc !== 5) begin n_errors++; $display("FAIL ps_rdy_cyc got %0d want 5", t_rdy_cyc); end
        n_checks++; if (t_rsp_cyc !== -1) begin n_errors++; $display("FAIL ps_no_rsp got %0d want -1", t_rsp_cyc); end
    endtask

    task automatic test_single_bit();
        logic [31:0] d;
        int          b;
        do_txn(1'b1, 16'h0080, 32'hCAFE1234, 4'hF);
        for (int it = 0; it < 8; it++) begin
            b    = (it == 0) ? 5 : int'($urandom_range(0, 38));
            d    = 32'hCAFE1234;
            flip = 39'h1 << b;
            do_txn(1'b0, 16'h0080, 32'h0, 4'h0);
            flip = '0;
            n_checks++; if (t_rsp_data !== d) begin n_errors++; $display("FAIL sb_rdata bit%0d got %h want %h", b, t_rsp_data, d); end
            n_checks++; if ({t_rsp_sb, t_rsp_db} !== 2'b10) begin n_errors++; $display("FAIL sb_flags bit%0d got %b want 10", b, {t_rsp_sb, t_rsp_db}); end
`ifdef EH2_DCCM_CORR_WB_EN
            n_checks++; if (t_wr_cyc !== 3) begin n_errors++; $display("FAIL sb_wb_cyc bit%0d got %0d want 3", b, t_wr_cyc); end
            n_checks++; if (t_wr_data !== ref_word(d)) begin n_errors++; $display("FAIL sb_wb_data bit%0d got %h want %h", b, t_wr_data, ref_word(d)); end
            n_checks++; if (t_wr_addr !== 16'h0080) begin n_errors++; $display("FAIL sb_wb_addr got %h want 0080", t_wr_addr); end
            n_checks++; if (t_rdy_cyc !== 4) begin n_errors++; $display("FAIL sb_rdy_cyc got %0d want 4", t_rdy_cyc); end
`else
            n_checks++; if (t_wr_cnt !== 0) begin n_errors++; $display("FAIL sb_no_wb got %0d want 0", t_wr_cnt); end
            n_checks++; if (t_rdy_cyc !== 3) begin n_errors++; $display("FAIL sb_rdy_cyc got %0d want 3", t_rdy_cyc); end
`endif
        end
    endtask

    task automatic test_double_bit();
        logic [31:0] raw;
        logic [38:0] f2;
        f2  = (39'h1 << 3) | (39'h1 << 17);
        do_txn(1'b1, 16'h00C0, 32'hA5A50F0F, 4'hF);
        raw = 32'hA5A50F0F ^ f2[31:0];
        flip = f2;
        do_txn(1'b0, 16'h00C0, 32'h0, 4'h0);
        n_checks++; if ({t_rsp_sb, t_rsp_db} !== 2'b01) begin n_errors++; $display("FAIL db_ld_flags got %b want 01", {t_rsp_sb, t_rsp_db}); end
        n_checks++; if (t_wr_cnt !== 0) begin n_errors++; $display("FAIL db_ld_wr got %0d want 0", t_wr_cnt); end
        do_txn(1'b1, 16'h00C0, 32'h000000EE, 4'b0001);
        n_checks++; if (t_rmw_cnt !== 1) begin n_errors++; $display("FAIL db_rmw_err got %0d want 1", t_rmw_cnt); end
        n_checks++; if (t_wr_cnt !== 0) begin n_errors++; $display("FAIL db_rmw_wr got %0d want 0", t_wr_cnt); end
        flip = '0;
        do_txn(1'b0, 16'h00C0, 32'h0, 4'h0);
        n_checks++; if (t_rsp_data !== 32'hA5A50F0F) begin n_errors++; $display("FAIL db_mem_kept got %h want a5a50f0f", t_rsp_data); end
        ecc_disable = 1'b1;
        flip = f2;
        do_txn(1'b0, 16'h00C0, 32'h0, 4'h0);
        n_checks++; if (t_rsp_data !== raw) begin n_errors++; $display("FAIL dis_rdata got %h want %h", t_rsp_data, raw); end
        n_checks++; if ({t_rsp_sb, t_rsp_db} !== 2'b00) begin n_errors++; $display("FAIL dis_flags got %b want 00", {t_rsp_sb, t_rsp_db}); end
        do_txn(1'b1, 16'h00C0, 32'h000000EE, 4'b0001);
        n_checks++; if (t_rmw_cnt !== 0) begin n_errors++; $display("FAIL dis_rmw_err got %0d want 0", t_rmw_cnt); end
        n_checks++; if (t_wr_data !== ref_word(ref_merge(raw, 32'hEE, 4'b0001))) begin n_errors++; $display("FAIL dis_rmw_data got %h want %h", t_wr_data, ref_word(ref_merge(raw, 32'hEE, 4'b0001))); end
        flip = '0;
        ecc_disable = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int bad;
        do_txn(1'b1, 16'h0100, 32'h12345678, 4'hF);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0100;
        req_wdata = 32'h0000FF00; req_be = 4'b0010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (dccm_rden !== 1'b1) begin n_errors++; $display("FAIL rm_in_rd got %b want 1", dccm_rden); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL rm_ready_rst got %b want 0", req_ready); end
        rst = 1'b0;
        bad = 0;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rm_ready_after got %b want 1", req_ready); end
        for (int c = 0; c < 6; c++) begin
            if (dccm_wren || rsp_valid) bad++;
            @(posedge clk); #1;
        end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL rm_no_activity got %0d want 0", bad); end
        do_txn(1'b0, 16'h0100, 32'h0, 4'h0);
        n_checks++; if (t_rsp_data !== 32'h12345678) begin n_errors++; $display("FAIL rm_mem_kept got %h want 12345678", t_rsp_data); end
    endtask

    task automatic test_random();
        logic [31:0] d, exp;
        logic [3:0]  be;
        logic [15:0] a;
        int          k, op;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            smem[i] = d;
            do_txn(1'b1, 16'h0200 + 16'(i * 4), d, 4'hF);
            n_checks++; if (t_wr_data !== ref_word(d)) begin n_errors++; $display("FAIL rnd_init_data[%0d] got %h want %h", i, t_wr_data, ref_word(d)); end
        end
        for (int i = 0; i < 30; i++) begin
            k  = int'($urandom_range(0, 7));
            op = int'($urandom_range(0, 2));
            a  = 16'h0200 + 16'(k * 4) + 16'($urandom_range(0, 3));
            d  = $urandom;
            be = (op == 1) ? 4'hF : 4'($urandom_range(0, 15));
            do_txn(op != 0, a, d, be);
            n_checks++; if (t_both !== 0) begin n_errors++; $display("FAIL rnd_both got %0d want 0", t_both); end
            if (op == 0) begin
                n_checks++; if (t_rsp_data !== smem[k] || t_rsp_cyc !== 3) begin n_errors++; $display("FAIL rnd_load[%0d] got %h@%0d want %h@3", i, t_rsp_data, t_rsp_cyc, smem[k]); end
            end else begin
                exp = ref_merge(smem[k], d, be);
                smem[k] = exp;
                n_checks++; if (t_wr_data !== ref_word(exp) || t_wr_addr !== 16'h0200 + 16'(k * 4)) begin n_errors++; $display("FAIL rnd_store[%0d] got %h@%h want %h", i, t_wr_data, t_wr_addr, ref_word(exp)); end
                n_checks++; if (t_rdy_cyc !== ((be == 4'hF) ? 2 : 5)) begin n_errors++; $display("FAIL rnd_rdy[%0d] got %0d be %h", i, t_rdy_cyc, be); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_store();
        test_clean_load();
        test_partial_store();
        test_single_bit();
        test_double_bit();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
